fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_pkg.sv | 39 +++
 rtl/sync_2ff.sv | 36 +++
 rtl/fifo_rd_ctrl.sv | 127 ++++++++++++
 tb/tb_fifo_rd_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared constants and pointer-code helpers for the asynchronous
//            FIFO read- and write-side controllers.
// Contents : c_addr_size / c_data_size default geometry,
//            bin2gray / gray2bin pointer conversions.
// Revision : 1.0  initial release
// ============================================================================
package fifo_pkg;

    // Default FIFO geometry: 16 words of 8 bits.
    localparam int c_addr_size = 4;
    localparam int c_data_size = 8;

    // The helpers work on a fixed 32-bit container so that any pointer
    // width up to 32 bits can use them. Callers zero-extend on the way in
    // and truncate on the way out. Zero-extension leaves Gray coding of the
    // low bits unchanged in both directions.
    localparam int c_calc_w = 32;
    typedef logic [c_calc_w-1:0] ptr_calc_t;

    // Binary to reflected Gray code.
    function automatic ptr_calc_t bin2gray(input ptr_calc_t bin);
        return bin ^ (bin >> 1);
    endfunction

    // Reflected Gray code to binary, as a prefix XOR starting at the MSB.
    function automatic ptr_calc_t gray2bin(input ptr_calc_t gray);
        ptr_calc_t bin;
        bin[c_calc_w-1] = gray[c_calc_w-1];
        for (int i = c_calc_w - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
// Module   : sync_2ff
// Purpose  : Two-flop clock-domain-crossing synchronizer. It is meant for
//            multi-bit buses only when at most one bit changes per source
//            update, as with a Gray-coded pointer.
// Ports    : r_clk  - destination clock
//            r_rst  - asynchronous active-high reset, clears both stages
//            d      - asynchronous input bus
//            q      - synchronized output (second stage)
// Revision : 1.0  initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 5
) (
    input  logic             r_clk,
    input  logic             r_rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // First stage can go metastable; only the second stage is consumed.
    logic [WIDTH-1:0] meta_q;

    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            meta_q <= '0;
            q      <= '0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule : sync_2ff
`default_nettype wire

// File: rtl/fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_ctrl
// Purpose  : Read-side controller of an asynchronous FIFO. It synchronizes
//            the Gray write pointer, tracks the read pointer, and drives a
//            registered valid/ready output stage from a combinational-read
//            memory.
// Ports    : r_clk, r_rst      - read clock, asynchronous active-high reset
//            w_ptr_gray        - Gray write pointer from the write domain
//            r_ptr_gray        - registered Gray read pointer to the write domain
//            r_addr            - memory read address
//            mem_rdata         - memory read data at r_addr
//            r_dout / r_valid / r_ready - output word handshake
//            r_empty           - no unread word left in memory
//            r_level           - unread words in memory (output reg excluded)
//            r_almost_empty    - r_level <= AE_THRESH
//                                (present only with FIFO_RD_ALMOST_EMPTY_EN)
// Config   : define FIFO_RD_ALMOST_EMPTY_EN to add the r_almost_empty port.
// Revision : 1.0  initial release
// ============================================================================
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDR_SIZE = c_addr_size,
    parameter int DATA_SIZE = c_data_size,
    parameter int AE_THRESH = 2
) (
    input  logic                 r_clk,
    input  logic                 r_rst,
    input  logic [ADDR_SIZE:0]   w_ptr_gray,
    output logic [ADDR_SIZE:0]   r_ptr_gray,
    output logic [ADDR_SIZE-1:0] r_addr,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [DATA_SIZE-1:0] r_dout,
    output logic                 r_valid,
    input  logic                 r_ready,
    output logic                 r_empty,
    output logic [ADDR_SIZE:0]   r_level
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    ,
    output logic                 r_almost_empty
`endif
);

    // The pointer carries one extra MSB so a completely full memory
    // (16 unread words) can be told apart from an empty one.
    localparam int c_ptr_w = ADDR_SIZE + 1;

    logic [c_ptr_w-1:0] wq2_ptr_gray;   // synchronized write pointer (Gray)
    logic [c_ptr_w-1:0] wq2_bin;        // synchronized write pointer (binary)
    logic [c_ptr_w-1:0] rd_bin;         // binary read pointer
    logic [c_ptr_w-1:0] rd_bin_next;
    logic [c_ptr_w-1:0] rd_gray_next;
    logic               pop;

    // ------------------------------------------------------------------
    // Write-pointer crossing. This is the only logic that samples w_ptr_gray.
    // ------------------------------------------------------------------
    sync_2ff #(
        .WIDTH (c_ptr_w)
    ) u_wptr_sync (
        .r_clk (r_clk),
        .r_rst (r_rst),
        .d     (w_ptr_gray),
        .q     (wq2_ptr_gray)
    );

    // ------------------------------------------------------------------
    // Status. Both compare operands are flops, so r_empty does not glitch.
    // Because the extra MSB is part of the compare, a wrap does not make
    // the memory look empty.
    // ------------------------------------------------------------------
    assign r_empty = (r_ptr_gray == wq2_ptr_gray);

    assign wq2_bin = c_ptr_w'(gray2bin(c_calc_w'(wq2_ptr_gray)));

    // The subtraction is modulo 2**c_ptr_w, so it stays correct across a
    // pointer wrap and ranges from 0 to 2**ADDR_SIZE.
    assign r_level = wq2_bin - rd_bin;

    assign r_addr  = rd_bin[ADDR_SIZE-1:0];

    // ------------------------------------------------------------------
    // Pop whenever memory has a word and the output stage is free, or is
    // being emptied this cycle. This gives one word per cycle under
    // continuous r_ready.
    // ------------------------------------------------------------------
    assign pop = !r_empty && (!r_valid || r_ready);

    assign rd_bin_next  = rd_bin + c_ptr_w'(1);
    assign rd_gray_next = c_ptr_w'(bin2gray(c_calc_w'(rd_bin_next)));

    // Read pointer. The Gray copy is registered from the incremented binary
    // value, so it changes by exactly one bit per pop.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            rd_bin     <= '0;
            r_ptr_gray <= '0;
        end else if (pop) begin
            rd_bin     <= rd_bin_next;
            r_ptr_gray <= rd_gray_next;
        end
    end

    // Output stage. r_dout is loaded only on a pop. It holds through both
    // backpressure and the drop of r_valid.
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            r_dout  <= '0;
            r_valid <= 1'b0;
        end else if (pop) begin
            r_dout  <= mem_rdata;
            r_valid <= 1'b1;
        end else if (r_valid && r_ready) begin
            // Word taken and nothing behind it in memory.
            r_valid <= 1'b0;
        end
    end

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    // Derived from registered values only. After reset r_level is 0, so
    // this output starts at 1.
    assign r_almost_empty = (r_level <= c_ptr_w'(AE_THRESH));
`endif

endmodule : fifo_rd_ctrl
`default_nettype wire

// File: tb/tb_fifo_rd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_rd_ctrl
// Purpose  : Self-checking bench for fifo_rd_ctrl (ADDR_SIZE=4, DATA_SIZE=8)
//            with a behavioural write side and memory, and a scoreboard
//            queue checked by a negedge monitor.
// Config   : FIFO_RD_ALMOST_EMPTY_EN adds the r_almost_empty checks.
// Revision : 1.0  initial release
// ============================================================================
module tb_fifo_rd_ctrl;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 16;

    logic          r_clk      = 1'b0;
    logic          r_rst      = 1'b1;
    logic [PW-1:0] w_ptr_gray = '0;
    logic          r_ready    = 1'b0;
    logic [DW-1:0] mem_rdata;
    wire  [PW-1:0] r_ptr_gray;
    wire  [AW-1:0] r_addr;
    wire  [DW-1:0] r_dout;
    wire           r_valid;
    wire           r_empty;
    wire  [PW-1:0] r_level;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    wire           r_almost_empty;
`endif

    logic [DW-1:0] mem [DEPTH];
    logic [PW-1:0] wbin = '0;
    logic [DW-1:0] exp_q [$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            accepted = 0;

    assign mem_rdata = mem[r_addr];

    fifo_rd_ctrl #(
        .ADDR_SIZE (AW),
        .DATA_SIZE (DW),
        .AE_THRESH (2)
    ) dut (
        .r_clk          (r_clk),
        .r_rst          (r_rst),
        .w_ptr_gray     (w_ptr_gray),
        .r_ptr_gray     (r_ptr_gray),
        .r_addr         (r_addr),
        .mem_rdata      (mem_rdata),
        .r_dout         (r_dout),
        .r_valid        (r_valid),
        .r_ready        (r_ready),
        .r_empty        (r_empty),
        .r_level        (r_level)
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        ,
        .r_almost_empty (r_almost_empty)
`endif
    );

    always #5 r_clk = ~r_clk;

    function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] to_bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    // Write side: throttles on a full memory, stores the word, bumps the
    // Gray write pointer and records the expected beat.
    task automatic write_word(input logic [DW-1:0] d);
        int guard = 0;
        while ((wbin - to_bin(r_ptr_gray)) == PW'(DEPTH)) begin
            tick();
            guard++;
            if (guard > 200) begin
                check("write_full_timeout", 32'(guard), 32'd0);
                return;
            end
        end
        mem[wbin[AW-1:0]] = d;
        exp_q.push_back(d);
        wbin       = wbin + 1'b1;
        w_ptr_gray = to_gray(wbin);
        tick();
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (exp_q.size() != 0 && guard < 500) begin
            tick();
            guard++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
        tick();
        check({name, "_valid_low"}, 32'(r_valid), 32'd0);
    endtask

    // Monitor: every presented word must match the head of the scoreboard;
    // a handshake retires it. r_ptr_gray must never move by more than one bit.
    logic [PW-1:0] prev_gray;
    logic          prev_ok = 1'b0;
    always @(negedge r_clk) begin
        if (!r_rst) begin
            if (prev_ok)
                check("gray_step", 32'($countones(r_ptr_gray ^ prev_gray) <= 1), 32'd1);
            if (r_valid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no word at %0t", r_dout, $time);
                end else begin
                    check("dout", 32'(r_dout), 32'(exp_q[0]));
                    if (r_ready) begin
                        void'(exp_q.pop_front());
                        accepted++;
                    end
                end
            end
            prev_ok = 1'b1;
        end else begin
            prev_ok = 1'b0;
        end
        prev_gray = r_ptr_gray;
    end

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 32'(r_valid),    32'd0);
        check({tag, "_empty"}, 32'(r_empty),    32'd1);
        check({tag, "_gray"},  32'(r_ptr_gray), 32'd0);
        check({tag, "_level"}, 32'(r_level),    32'd0);
        check({tag, "_addr"},  32'(r_addr),     32'd0);
        check({tag, "_dout"},  32'(r_dout),     32'd0);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        check({tag, "_ae"},    32'(r_almost_empty), 32'd1);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        // ---------------- reset state ----------------
        repeat (2) @(posedge r_clk);
        #1;
        check_reset_state("reset");
        r_rst = 1'b0;
        tick();

        // ---------------- single word, latency 3 edges ----------------
        r_ready    = 1'b0;
        mem[0]     = 8'hA5;
        exp_q.push_back(8'hA5);
        wbin       = 5'd1;
        w_ptr_gray = to_gray(wbin);
        tick();
        check("lat_edge1_valid", 32'(r_valid), 32'd0);
        tick();
        check("lat_edge2_valid", 32'(r_valid), 32'd0);
        check("lat_edge2_empty", 32'(r_empty), 32'd0);
        tick();
        check("lat_edge3_valid", 32'(r_valid), 32'd1);
        check("lat_edge3_dout",  32'(r_dout),  32'hA5);
        check("lat_edge3_empty", 32'(r_empty), 32'd1);
        repeat (4) tick();
        check("hold_valid", 32'(r_valid), 32'd1);
        check("hold_dout",  32'(r_dout),  32'hA5);
        r_ready = 1'b1;
        tick();
        check("single_valid_low", 32'(r_valid), 32'd0);
        check("single_empty",     32'(r_empty), 32'd1);
        check("single_accepted",  32'(accepted), 32'd1);
        r_ready = 1'b0;

        // ---------------- streaming: prime word then 16 in memory ----------------
        write_word(8'hFF);
        for (int i = 0; i < 16; i++) write_word(8'(i));
        repeat (4) tick();
        check("full_level", 32'(r_level), 32'd16);
        check("full_empty", 32'(r_empty), 32'd0);
        check("full_dout",  32'(r_dout),  32'hFF);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
        check("full_ae", 32'(r_almost_empty), 32'd0);
`endif
        r_ready = 1'b1;
        for (int k = 0; k <= 16; k++) begin
            check("stream_level", 32'(r_level), 32'(16 - k));
            check("stream_valid", 32'(r_valid), 32'd1);
`ifdef FIFO_RD_ALMOST_EMPTY_EN
            check("stream_ae", 32'(r_almost_empty), 32'((16 - k) <= 2));
`endif
            tick();
        end
        check("stream_end_valid", 32'(r_valid), 32'd0);
        check("stream_end_empty", 32'(r_empty), 32'd1);
        check("stream_end_queue", 32'(exp_q.size()), 32'd0);
        r_ready = 1'b0;

        // ---------------- backpressure 1010... over 8 words ----------------
        fork
            begin
                for (int i = 0; i < 8; i++) write_word(8'h30 + 8'(i));
            end
            begin
                for (int c = 0; c < 40; c++) begin
                    r_ready = (c % 2 == 0);
                    tick();
                end
            end
        join
        r_ready = 1'b1;
        drain("bp_drain");

        // ---------------- wrap: 40 words through 16-deep memory ----------------
        r_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) write_word(8'h40 + 8'(i));
            end
            begin
                for (int c = 0; c < 120; c++) begin
                    r_ready = (c % 3 != 2);
                    tick();
                end
            end
        join
        r_ready = 1'b1;
        drain("wrap_drain");
        // 1 + 17 + 8 + 40 = 66 words read, so the read pointer sits at 66 mod 32.
        check("wrap_ptr_gray", 32'(r_ptr_gray), 32'(to_gray(5'd2)));
        check("wrap_wbin",     32'(wbin),       32'd2);
        check("wrap_level",    32'(r_level),    32'd0);
        check("wrap_empty",    32'(r_empty),    32'd1);
        check("wrap_accepted", 32'(accepted),   32'd66);

        // ---------------- asynchronous reset mid-stream ----------------
        r_ready = 1'b0;
        for (int i = 0; i < 3; i++) write_word(8'h50 + 8'(i));
        repeat (5) tick();
        check("pre_rst_valid", 32'(r_valid), 32'd1);
        #2;
        r_rst      = 1'b1;
        wbin       = '0;
        w_ptr_gray = '0;
        exp_q.delete();
        #1;
        check_reset_state("midrst");
        @(posedge r_clk);
        #1;
        r_rst = 1'b0;
        tick();
        r_ready = 1'b1;
        write_word(8'h5A);
        drain("post_rst_drain");
        check("post_rst_gray", 32'(r_ptr_gray), 32'(to_gray(5'd1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fifo_rd_ctrl
`default_nettype wire
